// File: rtl/cpu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | cpu_pkg : opcode and ALU-operation encodings shared by the CPU core  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int unsigned OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_BNE   = 3'b100,
        OP_JMP   = 3'b101,
        OP_NOP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | sequencer : Moore control FSM for the accumulator CPU                |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sequencer
    import cpu_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            load_MAR,
    output logic            load_MDR,
    output logic            load_IR,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_ACC,
    output logic            PC_bus,
    output logic            Addr_bus,
    output logic            MDR_bus,
    output logic            ACC_bus,
    output logic            CS,
    output logic            R_NW,
    output logic [1:0]      ALU_op,
    output logic            halted
);

    // The opcode field can never be wider than the instruction word itself.
    localparam int unsigned C_OPC_W = (OP_W < WORD_W) ? OP_W : WORD_W;

    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_DECODE = 4'd3,
        S_READ   = 4'd4,
        S_EXEC   = 4'd5,
        S_WRITE0 = 4'd6,
        S_WRITE1 = 4'd7,
        S_BRANCH = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t  state_q;
    state_t  state_d;
    opcode_t w_opcode;

    assign w_opcode = opcode_t'(op[C_OPC_W-1:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_MAR = 1'b0;
        load_MDR = 1'b0;
        load_IR  = 1'b0;
        load_PC  = 1'b0;
        INC_PC   = 1'b0;
        load_ACC = 1'b0;
        PC_bus   = 1'b0;
        Addr_bus = 1'b0;
        MDR_bus  = 1'b0;
        ACC_bus  = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b1;
        ALU_op   = ALU_PASS;
        halted   = 1'b0;

        case (state_q)
            S_FETCH0: begin
                PC_bus   = 1'b1;
                load_MAR = 1'b1;
                state_d  = S_FETCH1;
            end
            S_FETCH1: begin
                CS       = 1'b1;
                load_MDR = mem_ready;
                if (mem_ready) state_d = S_FETCH2;
            end
            S_FETCH2: begin
                MDR_bus = 1'b1;
                load_IR = 1'b1;
                INC_PC  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                Addr_bus = 1'b1;
                load_MAR = 1'b1;
                case (w_opcode)
                    OP_LOAD, OP_ADD, OP_SUB: state_d = S_READ;
                    OP_STORE:                state_d = S_WRITE0;
                    OP_JMP:                  state_d = S_BRANCH;
                    OP_BNE:                  state_d = z_flag ? S_FETCH0 : S_BRANCH;
                    OP_HALT:                 state_d = S_HALT;
                    default:                 state_d = S_FETCH0;
                endcase
            end
            S_READ: begin
                CS       = 1'b1;
                load_MDR = mem_ready;
                if (mem_ready) state_d = S_EXEC;
            end
            S_EXEC: begin
                MDR_bus  = 1'b1;
                load_ACC = 1'b1;
                case (w_opcode)
                    OP_ADD:  ALU_op = ALU_ADD;
                    OP_SUB:  ALU_op = ALU_SUB;
                    default: ALU_op = ALU_PASS;
                endcase
                state_d = S_FETCH0;
            end
            S_WRITE0: begin
                ACC_bus  = 1'b1;
                load_MDR = 1'b1;
                state_d  = S_WRITE1;
            end
            S_WRITE1: begin
                CS   = 1'b1;
                R_NW = 1'b0;
                if (mem_ready) state_d = S_FETCH0;
            end
            S_BRANCH: begin
                Addr_bus = 1'b1;
                load_PC  = 1'b1;
                state_d  = S_FETCH0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_sequencer : randomized scoreboard bench for the control sequencer |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_sequencer;
    import cpu_pkg::*;

    // Output vector layout: {MAR,MDR,IR,PC,INC,ACC,PCB,ADB,MDB,ACB,CS,RNW,ALU[1:0],HALT}
    localparam logic [14:0] M_MAR = 15'h4000;
    localparam logic [14:0] M_MDR = 15'h2000;
    localparam logic [14:0] M_IR  = 15'h1000;
    localparam logic [14:0] M_PC  = 15'h0800;
    localparam logic [14:0] M_INC = 15'h0400;
    localparam logic [14:0] M_ACC = 15'h0200;
    localparam logic [14:0] M_PCB = 15'h0100;
    localparam logic [14:0] M_ADB = 15'h0080;
    localparam logic [14:0] M_MDB = 15'h0040;
    localparam logic [14:0] M_ACB = 15'h0020;
    localparam logic [14:0] M_CS  = 15'h0010;
    localparam logic [14:0] M_RNW = 15'h0008;
    localparam logic [14:0] M_HLT = 15'h0001;

    localparam logic [14:0] V_F0  = M_PCB | M_MAR | M_RNW;
    localparam logic [14:0] V_F1  = M_CS | M_RNW;
    localparam logic [14:0] V_F2  = M_MDB | M_IR | M_INC | M_RNW;
    localparam logic [14:0] V_DEC = M_ADB | M_MAR | M_RNW;
    localparam logic [14:0] V_RD  = M_CS | M_RNW;
    localparam logic [14:0] V_EX  = M_MDB | M_ACC | M_RNW;
    localparam logic [14:0] V_W0  = M_ACB | M_MDR | M_RNW;
    localparam logic [14:0] V_W1  = M_CS;
    localparam logic [14:0] V_BR  = M_ADB | M_PC | M_RNW;
    localparam logic [14:0] V_HLT = M_HLT | M_RNW;

    typedef struct {
        bit          mr;
        bit          z;
        bit          rst;
        logic [14:0] exp;
        string       tag;
    } step_t;

    logic       clk;
    logic       reset;
    logic [2:0] op_in;
    logic       z_flag;
    logic       mem_ready;
    logic       load_MAR, load_MDR, load_IR, load_PC, INC_PC, load_ACC;
    logic       PC_bus, Addr_bus, MDR_bus, ACC_bus, CS, R_NW, halted;
    logic [1:0] ALU_op;

    step_t       plan[$];
    logic [14:0] sb_exp[$];
    string       sb_tag[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [14:0] obs;
    logic [14:0] m_exp;
    string       m_tag;

    sequencer #(.WORD_W(8), .OP_W(3)) dut (
        .clock     (clk),
        .reset     (reset),
        .op        (op_in),
        .z_flag    (z_flag),
        .mem_ready (mem_ready),
        .load_MAR  (load_MAR),
        .load_MDR  (load_MDR),
        .load_IR   (load_IR),
        .load_PC   (load_PC),
        .INC_PC    (INC_PC),
        .load_ACC  (load_ACC),
        .PC_bus    (PC_bus),
        .Addr_bus  (Addr_bus),
        .MDR_bus   (MDR_bus),
        .ACC_bus   (ACC_bus),
        .CS        (CS),
        .R_NW      (R_NW),
        .ALU_op    (ALU_op),
        .halted    (halted)
    );

    assign obs = {load_MAR, load_MDR, load_IR, load_PC, INC_PC, load_ACC,
                  PC_bus, Addr_bus, MDR_bus, ACC_bus, CS, R_NW, ALU_op, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every cycle the DUT presents a control word, compare against the scoreboard.
    always @(negedge clk) begin
        if (sb_exp.size() > 0) begin
            m_exp = sb_exp.pop_front();
            m_tag = sb_tag.pop_front();
            checks = checks + 1;
            if (obs !== m_exp) begin
                errors = errors + 1;
                $display("FAIL %s cycle %0d got %b expected %b", m_tag, cycle, obs, m_exp);
            end
            checks = checks + 1;
            if ($countones({PC_bus, Addr_bus, MDR_bus, ACC_bus}) > 1) begin
                errors = errors + 1;
                $display("FAIL bus_onehot %s cycle %0d got %b expected at most one set",
                         m_tag, cycle, {PC_bus, Addr_bus, MDR_bus, ACC_bus});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle %0d got timeout expected completion", cycle);
        $fatal(1, "watchdog expired");
    end

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push_step(input bit mr, input bit z, input logic [14:0] e, input string tag);
        step_t s;
        s.mr  = mr;
        s.z   = z;
        s.rst = 1'b0;
        s.exp = e;
        s.tag = tag;
        plan.push_back(s);
    endtask

    // A memory access waits n cycles, then completes; read accesses strobe MDR on completion.
    task automatic mem_wait(input int n, input logic [14:0] base, input bit is_read, input string tag);
        for (int i = 0; i < n; i++) push_step(1'b0, rb(), base, tag);
        push_step(1'b1, rb(), is_read ? (base | M_MDR) : base, tag);
    endtask

    // Expected cycle-by-cycle control words for one instruction, then a reset cut if cut > 0.
    task automatic run_instr(input opcode_t o, input bit z, input int wf, input int wm,
                             input int nh, input int cut);
        int c;
        string nm;
        nm = o.name();
        c  = cut;
        plan.delete();
        push_step(rb(), rb(), V_F0, {nm, " FETCH0"});
        mem_wait(wf, V_F1, 1'b1, {nm, " FETCH1"});
        push_step(rb(), rb(), V_F2, {nm, " FETCH2"});
        push_step(rb(), z, V_DEC, {nm, " DECODE"});
        case (o)
            OP_LOAD, OP_ADD, OP_SUB: begin
                mem_wait(wm, V_RD, 1'b1, {nm, " READ"});
                push_step(rb(), rb(),
                          V_EX | ((o == OP_ADD) ? 15'h0002 : (o == OP_SUB) ? 15'h0004 : 15'h0000),
                          {nm, " EXEC"});
            end
            OP_STORE: begin
                push_step(rb(), rb(), V_W0, {nm, " WRITE0"});
                mem_wait(wm, V_W1, 1'b0, {nm, " WRITE1"});
            end
            OP_JMP: push_step(rb(), rb(), V_BR, {nm, " BRANCH"});
            OP_BNE: if (!z) push_step(rb(), rb(), V_BR, {nm, " BRANCH"});
            OP_HALT: begin
                for (int i = 0; i < nh; i++) push_step(rb(), rb(), V_HLT, {nm, " HALT"});
                c = plan.size();
            end
            default: ;
        endcase
        if (c < 0) c = $urandom_range(1, plan.size());
        if (c > 0 && c <= plan.size()) begin
            while (plan.size() > c) void'(plan.pop_back());
            plan[plan.size()-1].rst = 1'b1;
        end
        foreach (plan[i]) begin
            op_in     = o;
            mem_ready = plan[i].mr;
            z_flag    = plan[i].z;
            reset     = plan[i].rst;
            sb_exp.push_back(plan[i].exp);
            sb_tag.push_back(plan[i].rst ? {plan[i].tag, " +reset"} : plan[i].tag);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        opcode_t o;
        reset     = 1'b1;
        op_in     = 3'b000;
        z_flag    = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        sb_exp.push_back(V_F0);
        sb_tag.push_back("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(OP_LOAD,  1'b0, 0, 0, 0, 0);
        run_instr(OP_ADD,   1'b0, 0, 3, 0, 0);
        run_instr(OP_SUB,   1'b1, 1, 1, 0, 0);
        run_instr(OP_BNE,   1'b1, 0, 0, 0, 0);
        run_instr(OP_BNE,   1'b0, 0, 0, 0, 0);
        run_instr(OP_JMP,   1'b1, 2, 0, 0, 0);
        run_instr(OP_STORE, 1'b0, 0, 0, 0, 0);
        run_instr(OP_STORE, 1'b1, 1, 2, 0, 0);
        run_instr(OP_NOP,   1'b0, 0, 0, 0, 0);
        run_instr(OP_HALT,  1'b0, 0, 0, 20, 0);
        run_instr(OP_LOAD,  1'b0, 3, 0, 0, 3);
        run_instr(OP_ADD,   1'b0, 0, 2, 0, 6);

        for (int n = 0; n < 200; n++) begin
            o = opcode_t'($urandom_range(0, 7));
            run_instr(o, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(1, 4), ($urandom_range(0, 7) == 0) ? -1 : 0);
        end

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (sb_exp.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning the instruction/data word width.
REQ-002 The block SHALL have parameter OP_W, default 3, meaning the opcode field width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: port clock, input, 1 bit, rising-edge clock; port reset, input, 1 bit, synchronous active-high reset.
REQ-004 op  input  OP_W  opcode field from the instruction register.
REQ-005 z_flag  input  1  accumulator-zero flag.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 load_MAR, load_MDR, load_IR, load_PC, INC_PC, load_ACC  output  1 each  register load/increment strobes.
REQ-008 PC_bus, Addr_bus, MDR_bus, ACC_bus  output  1 each  source select for the internal datapath.
REQ-009 CS  output  1  memory chip select.
REQ-010 R_NW  output  1  memory access type, 1=read, 0=write.
REQ-011 ALU_op  output  2  00=pass MDR, 01=add, 10=subtract.
REQ-012 halted  output  1  processor stopped.

Function
REQ-013 Moore FSM; all outputs SHALL be decoded from the current state only (ALU_op also from op); every unlisted output SHALL be 0, and R_NW SHALL default to 1.
REQ-014 FETCH0: PC_bus=1, load_MAR=1; next FETCH1.
REQ-015 FETCH1: CS=1, R_NW=1, load_MDR=mem_ready; hold while mem_ready=0; next FETCH2.
REQ-016 FETCH2: MDR_bus=1, load_IR=1, INC_PC=1; next DECODE.
REQ-017 DECODE: Addr_bus=1, load_MAR=1; next by op:
  - LOAD/ADD/SUB -> READ;
  - STORE -> WRITE0;
  - JMP -> BRANCH;
  - BNE -> BRANCH if z_flag=0, else FETCH0;
  - NOP -> FETCH0;
  - HALT -> HALT.
REQ-018 READ: CS=1, R_NW=1, load_MDR=mem_ready; hold while mem_ready=0; next EXEC.
REQ-019 EXEC: MDR_bus=1, load_ACC=1, ALU_op=00/01/10 for LOAD/ADD/SUB; next FETCH0.
REQ-020 WRITE0: ACC_bus=1, load_MDR=1; next WRITE1.
REQ-021 WRITE1: CS=1, R_NW=0; hold while mem_ready=0; next FETCH0.
REQ-022 BRANCH: Addr_bus=1, load_PC=1; next FETCH0.
REQ-023 HALT: halted=1; remain in HALT until reset.
REQ-024 z_flag SHALL be sampled only in DECODE, at the clock edge leaving it.
REQ-025 At most one bus-select output SHALL be 1 in any cycle.
REQ-026 With zero wait states, cycle counts SHALL be:
  - LOAD/ADD/SUB: 6 cycles;
  - STORE: 6 cycles;
  - JMP and taken BNE: 5 cycles;
  - untaken BNE and NOP: 4 cycles.
  Each cycle of mem_ready=0 in FETCH1, READ or WRITE1 SHALL add one cycle.

Reset
REQ-027 reset=1 at a rising clock edge SHALL force state FETCH0 from any state, including mid-wait and HALT; FETCH0 outputs SHALL appear on the following cycle.
REQ-028 Reset SHALL take priority over mem_ready and all transitions.

Structure
REQ-029 The opcode encoding SHALL live in shared package cpu_pkg: LOAD=000, STORE=001, ADD=010, SUB=011, BNE=100, JMP=101, NOP=110, HALT=111.
REQ-030 The ALU_op enum SHALL also live in cpu_pkg.
REQ-031 The state enum SHALL be local to sequencer.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 reset for 1 cycle, then mem_ready=1 and op=LOAD -> states FETCH0, FETCH1, FETCH2, DECODE, READ, EXEC, FETCH0; load_ACC=1 with ALU_op=00 in cycle 6.
REQ-034 op=ADD, mem_ready held 0 for 3 cycles in READ -> CS=1 for 4 cycles, load_MDR=1 only in the 4th, total 9 cycles.
REQ-035 op=BNE, z_flag=1 -> returns to FETCH0 after DECODE, load_PC never 1; z_flag=0 -> load_PC=1 in cycle 5.
REQ-036 op=STORE -> load_MDR with ACC_bus in WRITE0, then R_NW=0 with CS=1 in WRITE1; no load_ACC.
REQ-037 op=HALT -> halted=1 from cycle 5 and held for 20 cycles; reset -> FETCH0, halted=0.
REQ-038 reset asserted during a FETCH1 wait -> next cycle PC_bus=1, load_MAR=1, CS=0.
